// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants and helpers for the game control path.
//   - side_e         : LEFT/RIGHT side selector, also used as a bit index into
//                      two-bit {right, left} vectors.
//   - DEFAULT_*      : default debounce / cooldown sizing for board builds.
//   - FRAME_TICK_DIV : clk cycles per game frame, used by the frame_tick generator.
//   - resolve_move() : turns held left/right levels into mutually exclusive
//                      move requests.
// No ports (package).
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic {
        SIDE_LEFT  = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_CNT_W           = 16;
    localparam int DEFAULT_ATTACK_COOLDOWN = 8;
    localparam int DEFAULT_CD_W            = 4;

    localparam int CLK_FREQ_HZ    = 50_000_000;
    localparam int FRAME_RATE_HZ  = 60;
    localparam int FRAME_TICK_DIV = CLK_FREQ_HZ / FRAME_RATE_HZ;

    // Opposing directions cancel: both held gives no movement, so the
    // character never sees left and right asserted together.
    function automatic logic [1:0] resolve_move(input logic [1:0] held);
        logic [1:0] move;
        move[SIDE_LEFT]  = held[SIDE_LEFT]  & ~held[SIDE_RIGHT];
        move[SIDE_RIGHT] = held[SIDE_RIGHT] & ~held[SIDE_LEFT];
        return move;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises one raw active-low key into the clk domain and debounces it.
// A new level is accepted only after the synchronised level has disagreed
// with the stable level for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   i_key_n   in   raw key, active-low, asynchronous to clk
//   o_stable  out  debounced level, active-high (1 = pressed)
//   o_rise    out  one-cycle pulse: o_stable goes 1 at the next clk edge
//   o_fall    out  one-cycle pulse: o_stable goes 0 at the next clk edge
// ---------------------------------------------------------------------------
module key_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_accept;

    assign w_differ = (r_sync2 != r_stable);
    // The edge that completes the run of disagreeing cycles flips the level.
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments let r_sync2 take the old r_sync1,
            // which is what makes this a real two-flop synchroniser.
            r_sync1 <= ~i_key_n;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_accept &  r_sync2;
    assign o_fall   = w_accept & ~r_sync2;

endmodule

// File: rtl/player_input_ctrl.sv
// ---------------------------------------------------------------------------
// player_input_ctrl
// Producer side of one player's control interface. Debounces the three board
// keys, latches movement at each frame tick and turns an attack press into a
// single-frame request, rate-limited by a frame-counted cooldown.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   frame_tick    in   one-cycle pulse per game frame; outputs update only on it
//   key_left_n    in   raw key, active-low, asynchronous
//   key_right_n   in   raw key, active-low, asynchronous
//   key_attack_n  in   raw key, active-low, asynchronous
//   left          out  move-left request, held for one frame
//   right         out  move-right request, held for one frame
//   attack        out  attack request, one frame per accepted press
//   cooldown      out  high while the cooldown counter is non-zero
// ---------------------------------------------------------------------------
module player_input_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int ATTACK_COOLDOWN = DEFAULT_ATTACK_COOLDOWN,
    parameter int CD_W            = DEFAULT_CD_W
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic key_left_n,
    input  logic key_right_n,
    input  logic key_attack_n,
    output logic left,
    output logic right,
    output logic attack,
    output logic cooldown
);

    localparam logic [CD_W-1:0] CD_INIT = CD_W'(ATTACK_COOLDOWN);

    logic w_stable_left,   w_rise_left,   w_fall_left;
    logic w_stable_right,  w_rise_right,  w_fall_right;
    logic w_stable_attack, w_rise_attack, w_fall_attack;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_left (
        .clk(clk), .rst(rst), .i_key_n(key_left_n),
        .o_stable(w_stable_left), .o_rise(w_rise_left), .o_fall(w_fall_left)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_right (
        .clk(clk), .rst(rst), .i_key_n(key_right_n),
        .o_stable(w_stable_right), .o_rise(w_rise_right), .o_fall(w_fall_right)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_attack (
        .clk(clk), .rst(rst), .i_key_n(key_attack_n),
        .o_stable(w_stable_attack), .o_rise(w_rise_attack), .o_fall(w_fall_attack)
    );

    // Movement only needs levels and the attack path only needs edges.
    logic w_unused_edges;
    assign w_unused_edges = ^{w_rise_left, w_fall_left, w_rise_right, w_fall_right,
                              w_stable_attack};

    // Bit order follows side_e: bit 0 = left, bit 1 = right.
    logic [1:0] w_held;
    logic [1:0] w_move;
    assign w_held = {w_stable_right, w_stable_left};
    assign w_move = resolve_move(w_held);

    logic            r_left, r_right, r_attack, r_cooldown;
    logic            r_armed;
    logic            r_pending;
    logic [CD_W-1:0] r_cd;

    // A press only counts once the key has been seen released since reset, so
    // a key held through reset cannot fire until it is released and re-pressed.
    logic w_arm_rise;
    logic w_pend;
    assign w_arm_rise = w_rise_attack & r_armed;
    // A press accepted in the same cycle as the tick is served by that tick.
    assign w_pend     = r_pending | w_arm_rise;

    logic            w_pending_next;
    logic            w_attack_next;
    logic [CD_W-1:0] w_cd_next;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_pending_next = w_pend;
        w_attack_next  = 1'b0;
        w_cd_next      = r_cd;
        if (frame_tick) begin
            w_pending_next = 1'b0;
            if (w_pend && (r_cd == '0)) begin
                w_attack_next = 1'b1;
                w_cd_next     = CD_INIT;
            end else if (r_cd != '0) begin
                // Covers both a press dropped during cooldown and an idle frame.
                w_cd_next = r_cd - CD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_attack   <= 1'b0;
            r_cooldown <= 1'b0;
            r_armed    <= 1'b0;
            r_pending  <= 1'b0;
            r_cd       <= '0;
        end else begin
            if (w_fall_attack) begin
                r_armed <= 1'b1;
            end else if (w_arm_rise) begin
                r_armed <= 1'b0;
            end
            r_pending <= w_pending_next;
            r_cd      <= w_cd_next;
            if (frame_tick) begin
                r_left     <= w_move[SIDE_LEFT];
                r_right    <= w_move[SIDE_RIGHT];
                r_attack   <= w_attack_next;
                r_cooldown <= (w_cd_next != '0);
            end
        end
    end

    assign left     = r_left;
    assign right    = r_right;
    assign attack   = r_attack;
    assign cooldown = r_cooldown;

endmodule

// File: tb/tb_player_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_input_ctrl
// Directed bench for player_input_ctrl with DEBOUNCE_CYCLES=4,
// ATTACK_COOLDOWN=2 and a frame_tick every 20 clk cycles.
// ---------------------------------------------------------------------------
module tb_player_input_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic frame_tick;
    logic key_left_n;
    logic key_right_n;
    logic key_attack_n;
    logic left;
    logic right;
    logic attack;
    logic cooldown;

    int total = 0;
    int bad   = 0;
    int phase = 0;

    typedef struct {
        logic l_n;
        logic r_n;
        logic exp_l;
        logic exp_r;
    } move_vec_t;

    move_vec_t vecs[6];

    always #5 clk = ~clk;

    player_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16),
        .ATTACK_COOLDOWN(2),
        .CD_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .key_left_n(key_left_n),
        .key_right_n(key_right_n),
        .key_attack_n(key_attack_n),
        .left(left),
        .right(right),
        .attack(attack),
        .cooldown(cooldown)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic l, input logic r,
                              input logic a, input logic c);
        check({tag, ".left"},     left,     l);
        check({tag, ".right"},    right,    r);
        check({tag, ".attack"},   attack,   a);
        check({tag, ".cooldown"}, cooldown, c);
    endtask

    // One clk cycle; frame_tick is high for the edge every 20th cycle.
    task automatic step();
        @(posedge clk);
        #1;
        phase      = (phase == 19) ? 0 : phase + 1;
        frame_tick = (phase == 19);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Returns #1 after the edge that sampled frame_tick.
    task automatic wait_tick();
        logic was;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 25 && !seen; i++) begin
            was = frame_tick;
            step();
            if (was) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL wait_tick: no frame_tick within 25 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_l;
        logic prev_r;

        vecs[0] = '{l_n: 1'b0, r_n: 1'b0, exp_l: 1'b0, exp_r: 1'b0};
        vecs[1] = '{l_n: 1'b0, r_n: 1'b1, exp_l: 1'b1, exp_r: 1'b0};
        vecs[2] = '{l_n: 1'b1, r_n: 1'b0, exp_l: 1'b0, exp_r: 1'b1};
        vecs[3] = '{l_n: 1'b1, r_n: 1'b1, exp_l: 1'b0, exp_r: 1'b0};
        vecs[4] = '{l_n: 1'b0, r_n: 1'b1, exp_l: 1'b1, exp_r: 1'b0};
        vecs[5] = '{l_n: 1'b1, r_n: 1'b1, exp_l: 1'b0, exp_r: 1'b0};

        // Reset with the attack key already held.
        rst          = 1'b1;
        frame_tick   = 1'b0;
        key_left_n   = 1'b1;
        key_right_n  = 1'b1;
        key_attack_n = 1'b0;
        steps(3);
        check_outs("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_outs("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // 3-cycle glitches are rejected.
        wait_tick();
        for (int g = 0; g < 3; g++) begin
            key_left_n = 1'b0;
            steps(3);
            key_left_n = 1'b1;
            steps(2);
        end
        check("glitch.stable", dut.u_deb_left.o_stable, 1'b0);
        wait_tick();
        check_outs("glitch", 1'b0, 1'b0, 1'b0, 1'b0);

        // Steady press: stable after exactly 2+4 cycles, output after the tick.
        key_left_n = 1'b0;
        steps(5);
        check("latency.stable_5", dut.u_deb_left.o_stable, 1'b0);
        step();
        check("latency.stable_6", dut.u_deb_left.o_stable, 1'b1);
        check("latency.left_before_tick", left, 1'b0);
        wait_tick();
        check_outs("steady_left", 1'b1, 1'b0, 1'b0, 1'b0);

        // Movement table; outputs must hold between ticks.
        prev_l = 1'b1;
        prev_r = 1'b0;
        for (int i = 0; i < 6; i++) begin
            key_left_n  = vecs[i].l_n;
            key_right_n = vecs[i].r_n;
            steps(10);
            check($sformatf("vec%0d.hold_left", i),  left,  prev_l);
            check($sformatf("vec%0d.hold_right", i), right, prev_r);
            wait_tick();
            check_outs($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r, 1'b0, 1'b0);
            prev_l = vecs[i].exp_l;
            prev_r = vecs[i].exp_r;
        end

        // Held-through-reset key: release, then press fires once.
        key_attack_n = 1'b1;
        wait_tick();
        check_outs("atk_release", 1'b0, 1'b0, 1'b0, 1'b0);
        key_attack_n = 1'b0;
        steps(10);
        check("atk_pre_tick", attack, 1'b0);
        wait_tick();
        check_outs("atk_fire", 1'b0, 1'b0, 1'b1, 1'b1);
        steps(10);
        check("atk_mid_frame", attack, 1'b1);
        wait_tick();
        check_outs("atk_hold1", 1'b0, 1'b0, 1'b0, 1'b1);
        wait_tick();
        check_outs("atk_hold2", 1'b0, 1'b0, 1'b0, 1'b0);
        wait_tick();
        check_outs("atk_hold3", 1'b0, 1'b0, 1'b0, 1'b0);
        wait_tick();
        check_outs("atk_hold4", 1'b0, 1'b0, 1'b0, 1'b0);

        // Press during cooldown is dropped; a press after cooldown fires.
        key_attack_n = 1'b1;
        steps(8);
        key_attack_n = 1'b0;
        wait_tick();
        check_outs("cd_fire", 1'b0, 1'b0, 1'b1, 1'b1);
        key_attack_n = 1'b1;
        steps(8);
        key_attack_n = 1'b0;
        wait_tick();
        check_outs("cd_drop", 1'b0, 1'b0, 1'b0, 1'b1);
        wait_tick();
        check_outs("cd_over", 1'b0, 1'b0, 1'b0, 1'b0);

        // Debounced rising edge lands on the tick edge itself.
        key_attack_n = 1'b1;
        steps(14);
        key_attack_n = 1'b0;
        wait_tick();
        check_outs("same_cycle_fire", 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset mid-frame with right mid-debounce.
        key_left_n = 1'b0;
        wait_tick();
        check_outs("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1);
        steps(5);
        key_right_n = 1'b0;
        steps(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_outs("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        steps(5);
        check("rst_restart.stable_5", dut.u_deb_right.o_stable, 1'b0);
        step();
        check("rst_restart.stable_6", dut.u_deb_right.o_stable, 1'b1);
        wait_tick();
        check_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
